// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - funct3 encodings for the supported access sizes
//   - FSM state type used by load_store_unit
//   - helpers classifying legal funct3 values for loads and stores
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Stores have no unsigned variants.
    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane handling for the load/store unit.
//   mem_read_i / mem_write_i : request type from EX/MEM
//   funct3_i                 : access size and sign
//   lane_i                   : byte lane, addr[1:0]
//   wdata_i                  : raw store data
//   rword_i                  : memory word currently addressed
//   strb_o                   : per-byte write strobe for stores
//   wdata_rep_o              : store data replicated into the lanes
//   rdata_ext_o              : selected and sign/zero-extended load data
//   err_o                    : illegal or misaligned request
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  strb_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misalign;

    // Store side: strobe picks the lanes, replication puts the data in every
    // lane it could land in so the strobe alone decides what is written.
    always_comb begin
        strb_o      = 4'b0000;
        wdata_rep_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                strb_o      = 4'b0001 << lane_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                strb_o      = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                strb_o      = 4'b1111;
                wdata_rep_o = wdata_i;
            end
            default: begin
                strb_o      = 4'b0000;
                wdata_rep_o = wdata_i;
            end
        endcase
    end

    // Load side: lane select then extension.
    assign byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        rdata_ext_o = 32'h0;
        case (funct3_i)
            F3_B:    rdata_ext_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_ext_o = {24'h0, byte_sel};
            F3_H:    rdata_ext_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_ext_o = {16'h0, half_sel};
            F3_W:    rdata_ext_o = rword_i;
            default: rdata_ext_o = 32'h0;
        endcase
    end

    assign misalign = (((funct3_i == F3_H) || (funct3_i == F3_HU)) && lane_i[0]) ||
                      ((funct3_i == F3_W) && (lane_i != 2'b00));

    always_comb begin
        err_o = 1'b0;
        if (mem_read_i && mem_write_i) begin
            err_o = 1'b1;
        end else if (mem_read_i) begin
            err_o = !load_f3_ok(funct3_i) || misalign;
        end else if (mem_write_i) begin
            err_o = !store_f3_ok(funct3_i) || misalign;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// MEM-stage load/store unit with an internal word-organised data memory and
// a fixed number of wait states per access.
//   clk, rstn  : clock, asynchronous active-low reset
//   mem_read   : load request
//   mem_write  : store request
//   funct3     : access size / sign (B, H, W, BU, HU)
//   addr       : byte address; upper bits beyond the memory size are ignored
//   wdata      : store data
//   readData   : extended load data, non-zero only in the completion cycle
//   stall      : access pending, pipeline must hold the request
//   access_err : illegal or misaligned request (no stall, no side effects)
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] readData,
    output logic        stall,
    output logic        access_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    lsu_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic [31:0]   rword;
    logic [31:0]   merged_word;
    logic [3:0]    strb;
    logic [31:0]   wdata_rep;
    logic [31:0]   rdata_ext;
    logic          req_err;
    logic          req_valid;
    logic          stall_raw;
    logic          complete;
    logic          write_en;
    logic          unused_addr;

    // Addresses wrap modulo the memory size; the high bits are deliberately
    // dropped.
    assign word_idx    = addr[2 +: AW];
    assign unused_addr = ^addr;

    // Asynchronous read so load data is available in the completion cycle
    // and a store's read-modify-write merge sees the current word.
    assign rword = mem_q[word_idx];

    lsu_align u_align (
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .funct3_i    (funct3),
        .lane_i      (addr[1:0]),
        .wdata_i     (wdata),
        .rword_i     (rword),
        .strb_o      (strb),
        .wdata_rep_o (wdata_rep),
        .rdata_ext_o (rdata_ext),
        .err_o       (req_err)
    );

    assign req_valid = (mem_read ^ mem_write) && !req_err;

    // Next-state logic. The request is held stable by the pipeline while
    // stalled, so req_valid still describes the same access in WAIT/RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall_raw = 1'b1;
                        cnt_d     = 3'(WAIT_STATES - 1);
                        state_d   = (WAIT_STATES == 1) ? RESP : WAIT;
                    end
                end
            end
            WAIT: begin
                stall_raw = 1'b1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                complete = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are combinational from inputs, so they are gated with rstn to
    // stay quiet while reset is asserted even if a request is presented.
    assign stall      = rstn && stall_raw;
    assign access_err = rstn && req_err && (state_q == IDLE);
    assign readData   = (rstn && complete && req_valid && mem_read) ? rdata_ext : 32'h0;

    // Store commit: merge the strobed lanes into the current word and write
    // the whole word at the edge that ends the completion cycle.
    assign write_en = rstn && complete && req_valid && mem_write;

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged_word[gi*8 +: 8] = strb[gi] ? wdata_rep[gi*8 +: 8] : rword[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[word_idx] <= merged_word;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit. Three instances with WAIT_STATES of
// 0, 2 and 7 are driven independently. Expected results are pushed to a
// scoreboard queue when a request is issued and popped when it completes.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        tb_mr [3];
    logic        tb_mw [3];
    logic [2:0]  tb_f3 [3];
    logic [31:0] tb_ad [3];
    logic [31:0] tb_wd [3];
    logic [31:0] tb_rd [3];
    logic        tb_st [3];
    logic        tb_er [3];

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    // Index 0: WAIT_STATES=0, index 1: WAIT_STATES=2, index 2: WAIT_STATES=7
    load_store_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rstn(rstn), .mem_read(tb_mr[0]), .mem_write(tb_mw[0]),
        .funct3(tb_f3[0]), .addr(tb_ad[0]), .wdata(tb_wd[0]),
        .readData(tb_rd[0]), .stall(tb_st[0]), .access_err(tb_er[0]));

    load_store_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .rstn(rstn), .mem_read(tb_mr[1]), .mem_write(tb_mw[1]),
        .funct3(tb_f3[1]), .addr(tb_ad[1]), .wdata(tb_wd[1]),
        .readData(tb_rd[1]), .stall(tb_st[1]), .access_err(tb_er[1]));

    load_store_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(7)) dut_ws7 (
        .clk(clk), .rstn(rstn), .mem_read(tb_mr[2]), .mem_write(tb_mw[2]),
        .funct3(tb_f3[2]), .addr(tb_ad[2]), .wdata(tb_wd[2]),
        .readData(tb_rd[2]), .stall(tb_st[2]), .access_err(tb_er[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] w);
        tb_mr[s] = rd;
        tb_mw[s] = wr;
        tb_f3[s] = f3;
        tb_ad[s] = a;
        tb_wd[s] = w;
    endtask

    // Called at a falling edge. Holds the request until the completion (or
    // error) cycle, checks it against the scoreboard, then returns at the
    // falling edge after the completion edge with the inputs cleared.
    task automatic access(input int s, input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_stalls);
        exp_t e;
        int   ns;
        bit   done;
        e.tag    = tag;
        e.data   = exp_data;
        e.err    = exp_err;
        e.stalls = exp_stalls;
        sb_q.push_back(e);
        drive(s, rd, wr, f3, a, w);
        ns   = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (tb_st[s] === 1'b1) begin
                ns++;
                chk({tag, "/rdata_in_stall"}, tb_rd[s], 32'h0);
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        e = sb_q.pop_front();
        if (!done) chk({e.tag, "/stall_stuck"}, {31'h0, tb_st[s]}, 32'h0);
        chk({e.tag, "/stalls"}, 32'(ns), 32'(e.stalls));
        chk({e.tag, "/rdata"}, tb_rd[s], e.data);
        chk({e.tag, "/err"}, {31'h0, tb_er[s]}, {31'h0, e.err});
        $display("[%0t] dut%0d %s: stalls=%0d rdata=%h err=%b", $time, s, e.tag, ns, tb_rd[s], tb_er[s]);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        rstn = 1'b0;

        // Reset state: outputs quiet even with requests presented
        drive(0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b1, F3_W, 32'h10, 32'h0);
        drive(2, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d/stall", i), {31'h0, tb_st[i]}, 32'h0);
            chk($sformatf("reset%0d/rdata", i), tb_rd[i], 32'h0);
            chk($sformatf("reset%0d/err", i), {31'h0, tb_er[i]}, 32'h0);
        end
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // WAIT_STATES = 2: word, byte/half extension, partial stores
        access(1, "sw_10",   1'b0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2);
        access(1, "lw_10",   1'b1, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2);
        access(1, "lb_13",   1'b1, 1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2);
        access(1, "lbu_13",  1'b1, 1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2);
        access(1, "lh_12",   1'b1, 1'b0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2);
        access(1, "lhu_10",  1'b1, 1'b0, F3_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 2);
        access(1, "sb_11",   1'b0, 1'b1, F3_B,  32'h11, 32'h00000055, 32'h0,        1'b0, 2);
        access(1, "lw_sb",   1'b1, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 2);
        access(1, "sh_12",   1'b0, 1'b1, F3_H,  32'h12, 32'h00001234, 32'h0,        1'b0, 2);
        access(1, "lw_sh",   1'b1, 1'b0, F3_W,  32'h10, 32'h0,        32'h123455EF, 1'b0, 2);

        // Error cases: no stall, no data, no memory update
        access(1, "sw_20",     1'b0, 1'b1, F3_W, 32'h20, 32'h0BADF00D, 32'h0, 1'b0, 2);
        access(1, "lw_mis22",  1'b1, 1'b0, F3_W, 32'h22, 32'h0,        32'h0, 1'b1, 0);
        access(1, "sh_mis21",  1'b0, 1'b1, F3_H, 32'h21, 32'h0000FFFF, 32'h0, 1'b1, 0);
        access(1, "both_rw",   1'b1, 1'b1, F3_W, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        access(1, "lw_20_chk", 1'b1, 1'b0, F3_W, 32'h20, 32'h0,        32'h0BADF00D, 1'b0, 2);

        // WAIT_STATES = 0: back-to-back, never stalls, aliasing
        access(0, "ws0_sw_10",  1'b0, 1'b1, F3_W, 32'h10,   32'h11111111, 32'h0,        1'b0, 0);
        access(0, "ws0_sw_14",  1'b0, 1'b1, F3_W, 32'h14,   32'h22222222, 32'h0,        1'b0, 0);
        access(0, "ws0_sb_17",  1'b0, 1'b1, F3_B, 32'h17,   32'h000000AB, 32'h0,        1'b0, 0);
        access(0, "ws0_lw_10",  1'b1, 1'b0, F3_W, 32'h10,   32'h0,        32'h11111111, 1'b0, 0);
        access(0, "ws0_lw_14",  1'b1, 1'b0, F3_W, 32'h14,   32'h0,        32'hAB222222, 1'b0, 0);
        access(0, "ws0_alias",  1'b1, 1'b0, F3_W, 32'h1010, 32'h0,        32'h11111111, 1'b0, 0);

        // WAIT_STATES = 7: seven stalls per access, illegal funct3
        access(2, "ws7_sw_alias", 1'b0, 1'b1, F3_W,  32'h1010, 32'hA5A5C3A5, 32'h0,        1'b0, 7);
        access(2, "ws7_lw_10",    1'b1, 1'b0, F3_W,  32'h10,   32'h0,        32'hA5A5C3A5, 1'b0, 7);
        access(2, "ws7_lhu_12",   1'b1, 1'b0, F3_HU, 32'h12,   32'h0,        32'h0000A5A5, 1'b0, 7);
        access(2, "ws7_lb_11",    1'b1, 1'b0, F3_B,  32'h11,   32'h0,        32'hFFFFFFC3, 1'b0, 7);
        access(2, "ws7_ld_f3bad", 1'b1, 1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 0);
        access(2, "ws7_st_f3bu",  1'b0, 1'b1, F3_BU, 32'h10,   32'h000000FF, 32'h0,        1'b1, 0);
        access(2, "ws7_lw_after", 1'b1, 1'b0, F3_W,  32'h10,   32'h0,        32'hA5A5C3A5, 1'b0, 7);

        // Reset in the middle of a store: the store must be dropped
        access(1, "sw_40_zero", 1'b0, 1'b1, F3_W, 32'h40, 32'h0, 32'h0, 1'b0, 2);
        drive(1, 1'b0, 1'b1, F3_W, 32'h40, 32'hCAFEF00D);
        #1;
        chk("rst_mid/stall_req", {31'h0, tb_st[1]}, 32'h1);
        @(negedge clk);
        #1;
        chk("rst_mid/stall_wait", {31'h0, tb_st[1]}, 32'h1);
        rstn = 1'b0;
        #1;
        chk("rst_mid/stall_rst", {31'h0, tb_st[1]}, 32'h0);
        chk("rst_mid/rdata_rst", tb_rd[1], 32'h0);
        @(negedge clk);
        #1;
        chk("rst_mid/stall_rst2", {31'h0, tb_st[1]}, 32'h0);
        chk("rst_mid/err_rst2", {31'h0, tb_er[1]}, 32'h0);
        drive(1, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        access(1, "lw_40_after_rst", 1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h0, 1'b0, 2);
        access(1, "lw_10_after_rst", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage load/store unit: accepts the load/store request from the EX/MEM register, performs the access into an internal word-organised data memory, and produces `readData` plus stall for the pipeline. It is the producer side of the MEM/WB interface: it generates the read data that MEM/WB captures, and it holds the pipeline while the access is pending. While `stall` is high, pipeline control freezes PC, IF/ID, ID/EX and EX/MEM, and injects a bubble into MEM/WB.

## Interface
- `DEPTH_WORDS`, default 1024: data memory size in 32-bit words; must be a power of two.
- `WAIT_STATES`, default 1, range 0..7: stall cycles per access.
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `mem_read`, in, 1: load request from EX/MEM.
- `mem_write`, in, 1: store request from EX/MEM.
- `funct3`, in, 3: access size and sign.
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `addr`, in, 32: byte address (ALU result).
- `wdata`, in, 32: store data; the low bytes are used for B and H.
- `readData`, out, 32: extended load data; valid in the cycle a load completes; 0 otherwise.
- `stall`, out, 1: access pending; the pipeline holds the request stable.
- `access_err`, out, 1: misaligned or illegal request, in the request cycle.

## Operation
- A request exists when `mem_read ^ mem_write`.
- Error conditions (`access_err` = 1, combinational, no stall, no memory update, `readData` = 0):
  - `mem_read & mem_write` both high.
  - H or HU access with `addr[0]` = 1.
  - W access with `addr[1:0]` != 0.
  - `funct3` outside {000, 001, 010, 100, 101} on a load.
  - `funct3` outside {000, 001, 010} on a store.
- Word index is `addr[2 +: log2(DEPTH_WORDS)]`. Upper address bits are ignored, so addresses wrap modulo memory size.
- Byte lane is `addr[1:0]`.
- Loads:
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
  - Memory read is asynchronous from the array.
  - `readData` is driven only in the completion cycle.
- Stores:
  - A 4-bit byte strobe is derived from size and lane.
  - `wdata` is replicated into the addressed lanes: B to all four lanes, H to both halves.
  - Only strobed bytes are written, at the rising edge that ends the completion cycle.
- FSM states: `IDLE`, `WAIT`, `RESP`. Counter `cnt` is 3 bits.
  - `IDLE`, no request or error: stay; `stall` = 0.
  - `IDLE`, valid request, `WAIT_STATES` = 0: the `IDLE` cycle is the completion cycle; stay in `IDLE`.
  - `IDLE`, valid request, `WAIT_STATES` >= 1: `stall` = 1 and `cnt` <= `WAIT_STATES`-1. Go to `RESP` if `WAIT_STATES` = 1, else to `WAIT`.
  - `WAIT`: `stall` = 1. If `cnt` = 1 go to `RESP`, else `cnt` <= `cnt`-1.
  - `RESP`: `stall` = 0; completion cycle; go to `IDLE`.
- Back-to-back requests: the next request is evaluated in the `IDLE` cycle following `RESP`. There is no bubble beyond `WAIT_STATES`.
- Store followed by a load to the same word returns the new data, because the store commits before the load's completion cycle.
- Memory contents are not reset.

## Timing
- Reset values: state `IDLE`, `cnt` 0. While `rstn` is low: `stall` = 0, `readData` = 0, `access_err` = 0.
- Reset mid-access: state returns to `IDLE` immediately. A pending store is dropped (no write); a pending load produces no data.
- Latency: each valid access asserts `stall` for exactly `WAIT_STATES` consecutive cycles. The completion cycle follows, with `stall` = 0.
  - With `WAIT_STATES` = 0, a valid access never stalls.
- `readData` and `access_err` are combinational from the request inputs and state. They are stable before the MEM/WB capture edge.
- Inputs must remain stable while `stall` = 1. Changes during a stall are not tracked (behaviour undefined); the bench must not do this.

## Structure
- Package `lsu_pkg` holds:
  - `funct3` localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - State enum `lsu_state_t`: `IDLE`, `WAIT`, `RESP`.
- Sub-module `lsu_align` (combinational) covers:
  - byte-strobe and write-data lane replication for stores;
  - lane select and sign/zero extension for loads;
  - misalignment/illegal detection.
- The top level holds the FSM, the counter and the memory array.

## Test plan
- `WAIT_STATES` = 2: SW 0xDEADBEEF to 0x10, then LW from 0x10.
  - `stall` is high for 2 cycles on each access.
  - Load completion gives `readData` = 0xDEADBEEF.
- Byte/half extension: after the word above, LB from 0x13 gives 0xFFFFFFDE. LBU from 0x13 gives 0x000000DE. LH from 0x12 gives 0xFFFFDEAD. LHU from 0x10 gives 0x0000BEEF.
- Partial store: SB 0x55 to 0x11, then LW from 0x10 gives 0xDEAD55EF. SH 0x1234 to 0x12, then LW gives 0x123455EF.
- Misaligned LW at 0x22 gives `access_err` = 1, `stall` = 0, `readData` = 0. Misaligned SH at 0x21 gives `access_err` = 1 and leaves memory unchanged.
- Back-to-back stores then loads with `WAIT_STATES` = 0: no stall ever. With `WAIT_STATES` = 7: exactly 7 stall cycles per access. Address 0x10 + 4*`DEPTH_WORDS` aliases 0x10.
- Reset mid-access: assert `rstn` = 0 during `WAIT` of an SW to 0x40 with old data 0x0, then release. `stall` and `readData` are 0 during reset, and a later LW from 0x40 returns 0x0.
